// File: rtl/lcd_pkg.sv
// Shared opcodes, font geometry, ROM layout and FSM encoding for the LCD character renderer.
package lcd_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam int FONT16_H = 16;
    localparam int FONT16_W = 8;
    localparam int FONT12_H = 12;
    localparam int FONT12_W = 6;

    localparam logic [11:0] ROM_BASE16 = 12'd0;
    localparam logic [11:0] ROM_BASE12 = 12'd1520;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ROM_RD,
        S_ROM_WAIT,
        S_PIX_HI,
        S_PIX_LO,
        S_CLIP,
        S_DONE
    } state_t;

    function automatic logic [11:0] font_addr(input logic big, input logic [6:0] glyph,
                                              input logic [3:0] row);
        if (big)
            return ROM_BASE16 + {1'b0, glyph, 4'b0000} + {8'b0, row};
        else
            return ROM_BASE12 + ({5'b0, glyph} * 12'd12) + {8'b0, row};
    endfunction

endpackage

// File: rtl/lcd_show_char_if.sv
// Request, font-ROM and SPI-writer signals of the character renderer; master = surroundings, slave = renderer.
interface lcd_show_char_if;

    logic        show_char_flag;
    logic [6:0]  ascii_num;
    logic [8:0]  start_x;
    logic [8:0]  start_y;
    logic        en_size;
    logic        rom_rd_en;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data;
    logic        wr_en;
    logic [8:0]  wr_data;
    logic        wr_done;
    logic        show_char_done;
    logic        busy;
`ifdef LCD_CHAR_CLIP_EN
    logic        clip_err;

    modport master (
        output show_char_flag, ascii_num, start_x, start_y, en_size, rom_data, wr_done,
        input  rom_rd_en, rom_addr, wr_en, wr_data, show_char_done, busy, clip_err
    );
    modport slave (
        input  show_char_flag, ascii_num, start_x, start_y, en_size, rom_data, wr_done,
        output rom_rd_en, rom_addr, wr_en, wr_data, show_char_done, busy, clip_err
    );
`else
    modport master (
        output show_char_flag, ascii_num, start_x, start_y, en_size, rom_data, wr_done,
        input  rom_rd_en, rom_addr, wr_en, wr_data, show_char_done, busy
    );
    modport slave (
        input  show_char_flag, ascii_num, start_x, start_y, en_size, rom_data, wr_done,
        output rom_rd_en, rom_addr, wr_en, wr_data, show_char_done, busy
    );
`endif

endinterface

// File: rtl/lcd_win_seq.sv
// Maps window-set step 0..10 to the CASET/RASET/RAMWR command+data byte (bit8 = data).
// Purely combinational; the caller holds step until the writer acknowledges each byte.
module lcd_win_seq
    import lcd_pkg::*;
(
    input  logic [15:0] xs,
    input  logic [15:0] xe,
    input  logic [15:0] ys,
    input  logic [15:0] ye,
    input  logic [3:0]  step,
    output logic [8:0]  wr_byte
);

    always_comb begin
        wr_byte = 9'h000;
        case (step)
            4'd0:    wr_byte = {1'b0, CMD_CASET};
            4'd1:    wr_byte = {1'b1, xs[15:8]};
            4'd2:    wr_byte = {1'b1, xs[7:0]};
            4'd3:    wr_byte = {1'b1, xe[15:8]};
            4'd4:    wr_byte = {1'b1, xe[7:0]};
            4'd5:    wr_byte = {1'b0, CMD_RASET};
            4'd6:    wr_byte = {1'b1, ys[15:8]};
            4'd7:    wr_byte = {1'b1, ys[7:0]};
            4'd8:    wr_byte = {1'b1, ye[15:8]};
            4'd9:    wr_byte = {1'b1, ye[7:0]};
            4'd10:   wr_byte = {1'b0, CMD_RAMWR};
            default: wr_byte = 9'h000;
        endcase
    end

endmodule

// File: rtl/lcd_show_char.sv
// Renders one glyph: 11 window bytes then 2*W*H RGB565 bytes, each byte held until wr_done.
// Optional LCD_CHAR_CLIP_EN rejects off-panel windows at accept and pulses clip_err with done.
module lcd_show_char
    import lcd_pkg::*;
#(
    parameter int          LCD_W    = 240,
    parameter int          LCD_H    = 320,
    parameter logic [15:0] FG_COLOR = 16'hFFFF,
    parameter logic [15:0] BG_COLOR = 16'h0000,
    parameter int          CHAR_CNT = 95
) (
    input logic            sys_clk,
    input logic            sys_rst_n,
    lcd_show_char_if.slave bus
);

    localparam logic [6:0] GLYPH_LIM = 7'(CHAR_CNT);

    state_t      state, state_nxt;
    logic        sent;
    logic [3:0]  step;
    logic [3:0]  row;
    logic [2:0]  col;
    logic [7:0]  shift;
    logic [6:0]  glyph;
    logic        big;
    logic [8:0]  xs;
    logic [8:0]  ys;
    logic [2:0]  w_last;
    logic [3:0]  h_last;
    logic [15:0] xs16, xe16, ys16, ye16;
    logic [8:0]  win_byte;
    logic [15:0] pix_color;
    logic        byte_done;

    assign w_last    = big ? 3'(FONT16_W - 1) : 3'(FONT12_W - 1);
    assign h_last    = big ? 4'(FONT16_H - 1) : 4'(FONT12_H - 1);
    assign xs16      = {7'b0, xs};
    assign ys16      = {7'b0, ys};
    assign xe16      = xs16 + {13'b0, w_last};
    assign ye16      = ys16 + {12'b0, h_last};
    assign pix_color = shift[7] ? FG_COLOR : BG_COLOR;
    // wr_done only counts once our strobe for the current byte has gone out
    assign byte_done = sent & bus.wr_done;

`ifdef LCD_CHAR_CLIP_EN
    logic        clip_hit, clip_q;
    logic [15:0] xe_in, ye_in;
    assign xe_in    = {7'b0, bus.start_x} + (bus.en_size ? 16'(FONT16_W - 1) : 16'(FONT12_W - 1));
    assign ye_in    = {7'b0, bus.start_y} + (bus.en_size ? 16'(FONT16_H - 1) : 16'(FONT12_H - 1));
    assign clip_hit = (xe_in >= 16'(LCD_W)) || (ye_in >= 16'(LCD_H));
    assign bus.clip_err = (state == S_DONE) & clip_q;
`endif

    lcd_win_seq u_win (
        .xs      (xs16),
        .xe      (xe16),
        .ys      (ys16),
        .ye      (ye16),
        .step    (step),
        .wr_byte (win_byte)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= S_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt          = state;
        bus.wr_en          = 1'b0;
        bus.wr_data        = 9'h000;
        bus.rom_rd_en      = 1'b0;
        bus.rom_addr       = 12'h000;
        bus.show_char_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.show_char_flag) begin
`ifdef LCD_CHAR_CLIP_EN
                    state_nxt = clip_hit ? S_CLIP : S_CMD;
`else
                    state_nxt = S_CMD;
`endif
                end
            end
            S_CMD: begin
                bus.wr_en   = ~sent;
                bus.wr_data = win_byte;
                if (byte_done && step == 4'd10) state_nxt = S_ROM_RD;
            end
            S_ROM_RD: begin
                bus.rom_rd_en = 1'b1;
                bus.rom_addr  = font_addr(big, glyph, row);
                state_nxt     = S_ROM_WAIT;
            end
            S_ROM_WAIT: state_nxt = S_PIX_HI;
            S_PIX_HI: begin
                bus.wr_en   = ~sent;
                bus.wr_data = {1'b1, pix_color[15:8]};
                if (byte_done) state_nxt = S_PIX_LO;
            end
            S_PIX_LO: begin
                bus.wr_en   = ~sent;
                bus.wr_data = {1'b1, pix_color[7:0]};
                if (byte_done) begin
                    if (col != w_last)      state_nxt = S_PIX_HI;
                    else if (row != h_last) state_nxt = S_ROM_RD;
                    else                    state_nxt = S_DONE;
                end
            end
            S_CLIP: state_nxt = S_DONE;
            S_DONE: begin
                bus.show_char_done = 1'b1;
                state_nxt          = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.busy = (state != S_IDLE) && (state != S_DONE);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sent  <= 1'b0;
            step  <= '0;
            row   <= '0;
            col   <= '0;
            shift <= '0;
            glyph <= '0;
            big   <= 1'b0;
            xs    <= '0;
            ys    <= '0;
`ifdef LCD_CHAR_CLIP_EN
            clip_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.show_char_flag) begin
                        glyph <= (bus.ascii_num >= GLYPH_LIM) ? 7'd0 : bus.ascii_num;
                        big   <= bus.en_size;
                        xs    <= bus.start_x;
                        ys    <= bus.start_y;
                        sent  <= 1'b0;
                        step  <= '0;
                        row   <= '0;
                        col   <= '0;
`ifdef LCD_CHAR_CLIP_EN
                        clip_q <= clip_hit;
`endif
                    end
                end
                S_CMD: begin
                    if (byte_done) begin
                        sent <= 1'b0;
                        step <= step + 4'd1;
                    end else if (!sent) begin
                        sent <= 1'b1;
                    end
                end
                S_ROM_WAIT: shift <= bus.rom_data;
                S_PIX_HI: begin
                    if (byte_done)  sent <= 1'b0;
                    else if (!sent) sent <= 1'b1;
                end
                S_PIX_LO: begin
                    if (byte_done) begin
                        sent <= 1'b0;
                        if (col == w_last) begin
                            col <= '0;
                            row <= row + 4'd1;
                        end else begin
                            col   <= col + 3'd1;
                            shift <= {shift[6:0], 1'b0};
                        end
                    end else if (!sent) begin
                        sent <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_show_char.sv
// Directed + randomized bench for lcd_show_char with a 1-cycle font ROM and a 3-cycle SPI writer.
module tb_lcd_show_char;

    localparam logic [15:0] FG = 16'hFFFF;
    localparam logic [15:0] BG = 16'h0000;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    lcd_show_char_if bus ();

    lcd_show_char dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    logic [7:0]  font [0:4095];
    logic [8:0]  got_bytes [$];
    logic [11:0] got_rom [$];
    logic [8:0]  exp_bytes [$];
    logic [11:0] exp_rom [$];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int clip_cnt = 0;
    int last_wrdone_cyc = 0;
    int proto_err = 0;
    int pend = 0;
    logic [8:0] held = '0;
    logic busy_at_done = 1'b0;
    int b0, r0, d0, p0, c0, acc_cyc;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(posedge sys_clk) begin
        if (!sys_rst_n) bus.rom_data <= 8'h00;
        else if (bus.rom_rd_en) bus.rom_data <= font[bus.rom_addr];
    end

    // Writer: takes a byte on wr_en, returns wr_done 3 cycles later, polices the byte rule.
    always @(posedge sys_clk) begin
        bus.wr_done <= 1'b0;
        if (!sys_rst_n) begin
            pend <= 0;
        end else if (pend > 0) begin
            if (bus.wr_en) proto_err <= proto_err + 1;
            if (bus.wr_data !== held) proto_err <= proto_err + 1;
            pend <= pend - 1;
            if (pend == 1) bus.wr_done <= 1'b1;
        end else if (bus.wr_en) begin
            got_bytes.push_back(bus.wr_data);
            held <= bus.wr_data;
            pend <= 3;
        end
    end

    always @(negedge sys_clk) begin
        if (bus.rom_rd_en) got_rom.push_back(bus.rom_addr);
        if (bus.wr_done) last_wrdone_cyc = cyc;
        if (bus.show_char_done) begin
            done_cnt     = done_cnt + 1;
            done_cyc     = cyc;
            busy_at_done = bus.busy;
        end
`ifdef LCD_CHAR_CLIP_EN
        if (bus.clip_err) clip_cnt = clip_cnt + 1;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push_word(input int v);
        exp_bytes.push_back(9'h100 | 9'((v >> 8) & 255));
        exp_bytes.push_back(9'h100 | 9'(v & 255));
    endfunction

    // Reference: window commands, then each glyph row left-to-right as hi/lo colour bytes.
    function automatic void build_expected(input int ascii, input int x, input int y, input int size);
        int g, w, h, base;
        logic [7:0]  rb;
        logic [15:0] c;
        exp_bytes.delete();
        exp_rom.delete();
        g    = (ascii >= 95) ? 0 : ascii;
        w    = size ? 8 : 6;
        h    = size ? 16 : 12;
        base = size ? g * 16 : 1520 + g * 12;
        exp_bytes.push_back(9'h02A);
        push_word(x);
        push_word(x + w - 1);
        exp_bytes.push_back(9'h02B);
        push_word(y);
        push_word(y + h - 1);
        exp_bytes.push_back(9'h02C);
        for (int r = 0; r < h; r++) begin
            rb = font[base + r];
            exp_rom.push_back(12'(base + r));
            for (int k = 0; k < w; k++) begin
                c = rb[7 - k] ? FG : BG;
                exp_bytes.push_back({1'b1, c[15:8]});
                exp_bytes.push_back({1'b1, c[7:0]});
            end
        end
    endfunction

    task automatic start_char(input int ascii, input int x, input int y, input int size, input string tag);
        b0 = got_bytes.size();
        r0 = got_rom.size();
        d0 = done_cnt;
        p0 = proto_err;
        c0 = clip_cnt;
        @(negedge sys_clk);
        bus.show_char_flag = 1'b1;
        bus.ascii_num      = 7'(ascii);
        bus.start_x        = 9'(x);
        bus.start_y        = 9'(y);
        bus.en_size        = size[0];
        @(negedge sys_clk);
        bus.show_char_flag = 1'b0;
        acc_cyc = cyc;
        check({tag, " busy_after_accept"}, 32'(bus.busy), 32'd1);
    endtask

    task automatic finish_char(input string tag);
        logic [31:0] obs;
        for (int i = 0; i < 4000 && done_cnt == d0; i++) @(negedge sys_clk);
        repeat (20) @(negedge sys_clk);
        check({tag, " done_count"}, 32'(done_cnt - d0), 32'd1);
        check({tag, " done_latency"}, 32'(done_cyc - last_wrdone_cyc), 32'd1);
        check({tag, " busy_at_done"}, 32'(busy_at_done), 32'd0);
        check({tag, " byte_count"}, 32'(got_bytes.size() - b0), 32'(exp_bytes.size()));
        check({tag, " protocol"}, 32'(proto_err - p0), 32'd0);
        for (int i = 0; i < exp_bytes.size(); i++) begin
            obs = (b0 + i < got_bytes.size()) ? 32'(got_bytes[b0 + i]) : 32'hDEAD;
            check($sformatf("%s byte%0d", tag, i), obs, 32'(exp_bytes[i]));
        end
        check({tag, " rom_count"}, 32'(got_rom.size() - r0), 32'(exp_rom.size()));
        for (int i = 0; i < exp_rom.size(); i++) begin
            obs = (r0 + i < got_rom.size()) ? 32'(got_rom[r0 + i]) : 32'hDEAD;
            check($sformatf("%s rom%0d", tag, i), obs, 32'(exp_rom[i]));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " wr_en"}, 32'(bus.wr_en), 32'd0);
        check({tag, " wr_data"}, 32'(bus.wr_data), 32'd0);
        check({tag, " rom_rd_en"}, 32'(bus.rom_rd_en), 32'd0);
        check({tag, " rom_addr"}, 32'(bus.rom_addr), 32'd0);
        check({tag, " done"}, 32'(bus.show_char_done), 32'd0);
        check({tag, " busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int ra, rx, ry, rs;
        bus.show_char_flag = 1'b0;
        bus.ascii_num      = '0;
        bus.start_x        = '0;
        bus.start_y        = '0;
        bus.en_size        = 1'b0;
        for (int a = 0; a < 4096; a++) font[a] = 8'($urandom);
        for (int a = 0; a < 16; a++) font[a] = 8'h00;
        for (int a = 1520; a < 1532; a++) font[a] = 8'h00;
        font[640 + 3] = 8'hC3;

        repeat (3) @(negedge sys_clk);
        check_idle_outputs("reset");
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        build_expected(40, 72, 16, 1);
        start_char(40, 72, 16, 1, "H16");
        finish_char("H16");

        build_expected(0, 8, 48, 0);
        start_char(0, 8, 48, 0, "space12");
        finish_char("space12");

        build_expected(33, 100, 200, 1);
        start_char(33, 100, 200, 1, "busyflag");
        repeat (40) @(negedge sys_clk);
        bus.show_char_flag = 1'b1;
        bus.ascii_num      = 7'd5;
        bus.start_x        = 9'd3;
        bus.en_size        = 1'b0;
        @(negedge sys_clk);
        bus.show_char_flag = 1'b0;
        finish_char("busyflag");

        build_expected(100, 20, 20, 1);
        start_char(100, 20, 20, 1, "oorange");
        finish_char("oorange");

        start_char(50, 30, 40, 1, "midreset");
        for (int i = 0; i < 2000 && got_bytes.size() < b0 + 40; i++) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        build_expected(50, 30, 40, 1);
        start_char(50, 30, 40, 1, "afterreset");
        finish_char("afterreset");

        for (int n = 0; n < 4; n++) begin
            ra = int'($urandom_range(0, 127));
            rx = int'($urandom_range(0, 232));
            ry = int'($urandom_range(0, 304));
            rs = int'($urandom_range(0, 1));
            build_expected(ra, rx, ry, rs);
            start_char(ra, rx, ry, rs, $sformatf("rand%0d", n));
            finish_char($sformatf("rand%0d", n));
        end

`ifdef LCD_CHAR_CLIP_EN
        start_char(10, 236, 0, 1, "clip");
        for (int i = 0; i < 50 && done_cnt == d0; i++) @(negedge sys_clk);
        repeat (10) @(negedge sys_clk);
        check("clip done_count", 32'(done_cnt - d0), 32'd1);
        check("clip clip_err", 32'(clip_cnt - c0), 32'd1);
        check("clip done_latency", 32'(done_cyc - acc_cyc), 32'd1);
        check("clip bytes", 32'(got_bytes.size() - b0), 32'd0);
        check("clip rom", 32'(got_rom.size() - r0), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
